// File: rtl/uart_lcd_ctrl.sv
// Byte stream from a UART receiver to an HD44780-style character LCD, with cursor tracking and line wrap.
// Optional macro UART_LCD_BREAK_CLEAR_EN: a receiver break flushes the FIFO and clears the display.
module uart_lcd_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LCD_COLS   = 16
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_break_i,
  output logic       rx_en_o,
  output logic       lcd_req_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o,
  input  logic       lcd_ack_i,
  output logic       fifo_ovf_o,
  output logic       busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned COL_W = $clog2(LCD_COLS + 1);

  typedef enum logic [2:0] {INIT, IDLE, DECODE, SEND_CMD, SEND_CHR, WAIT_ACK} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               line_q, line_d;
  logic [1:0]         idx_q, idx_d;
  logic               init_done_q, init_done_d;
  logic               chr_pend_q, chr_pend_d;
  logic [7:0]         pend_byte_q, pend_byte_d;
  logic               clr_pend_q, clr_pend_d;
  logic               req_d, rs_d;
  logic [7:0]         data_d;
  logic               full, empty, push, pop, brk;
  logic [7:0]         head;

`ifdef UART_LCD_BREAK_CLEAR_EN
  assign brk = rx_break_i;
`else
  logic unused_break;
  assign brk          = 1'b0;
  assign unused_break = rx_break_i;
`endif

  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem[rd_ptr];
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign push  = rx_valid_i && (!full || pop);
  assign cnt_d = brk ? '0 : CNT_W'(cnt_q + CNT_W'(push) - CNT_W'(pop));

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) state_q <= INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_d       = lcd_req_o;
    rs_d        = lcd_rs_o;
    data_d      = lcd_data_o;
    col_d       = col_q;
    line_d      = line_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    chr_pend_d  = chr_pend_q;
    pend_byte_d = pend_byte_q;
    clr_pend_d  = clr_pend_q | brk;
    pop         = 1'b0;
    case (state_q)
      INIT: begin
        rs_d    = 1'b0;
        data_d  = init_cmd(idx_q);
        req_d   = 1'b1;
        state_d = WAIT_ACK;
      end
      IDLE: begin
        if (clr_pend_q)  state_d = SEND_CMD;
        else if (!empty) state_d = DECODE;
      end
      // The first transfer is launched straight from DECODE to keep receive-to-request latency short
      DECODE: begin
        state_d = IDLE;
        if (!empty) begin
          pop = 1'b1;
          if (head >= 8'h20 && head <= 8'h7E) begin
            req_d   = 1'b1;
            state_d = WAIT_ACK;
            if (col_q == COL_W'(LCD_COLS)) begin
              line_d      = ~line_q;
              col_d       = '0;
              rs_d        = 1'b0;
              data_d      = line_q ? 8'h80 : 8'hC0;
              chr_pend_d  = 1'b1;
              pend_byte_d = head;
            end else begin
              rs_d   = 1'b1;
              data_d = head;
              col_d  = COL_W'(col_q + COL_W'(1));
            end
          end else if (head == 8'h0A || head == 8'h0D) begin
            line_d  = ~line_q;
            col_d   = '0;
            rs_d    = 1'b0;
            data_d  = line_q ? 8'h80 : 8'hC0;
            req_d   = 1'b1;
            state_d = WAIT_ACK;
          end else if (head == 8'h0C) begin
            line_d  = 1'b0;
            col_d   = '0;
            rs_d    = 1'b0;
            data_d  = 8'h01;
            req_d   = 1'b1;
            state_d = WAIT_ACK;
          end
        end
      end
      SEND_CMD: begin
        line_d     = 1'b0;
        col_d      = '0;
        rs_d       = 1'b0;
        data_d     = 8'h01;
        req_d      = 1'b1;
        clr_pend_d = brk;
        chr_pend_d = 1'b0;
        state_d    = WAIT_ACK;
      end
      SEND_CHR: begin
        rs_d       = 1'b1;
        data_d     = pend_byte_q;
        req_d      = 1'b1;
        col_d      = COL_W'(col_q + COL_W'(1));
        chr_pend_d = 1'b0;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (lcd_ack_i) begin
          req_d = 1'b0;
          if (!init_done_q) begin
            if (idx_q == 2'd3) begin
              init_done_d = 1'b1;
              state_d     = IDLE;
            end else begin
              idx_d   = 2'(idx_q + 2'd1);
              state_d = INIT;
            end
          end else if (clr_pend_d) begin
            chr_pend_d = 1'b0;
            state_d    = SEND_CMD;
          end else if (chr_pend_q) begin
            state_d = SEND_CHR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_q       <= '0;
      col_q       <= '0;
      line_q      <= 1'b0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      chr_pend_q  <= 1'b0;
      pend_byte_q <= '0;
      clr_pend_q  <= 1'b0;
      lcd_req_o   <= 1'b0;
      lcd_rs_o    <= 1'b0;
      lcd_data_o  <= '0;
      rx_en_o     <= 1'b0;
      fifo_ovf_o  <= 1'b0;
      busy_o      <= 1'b1;
    end else begin
      if (brk) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
        if (pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      end
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      chr_pend_q  <= chr_pend_d;
      pend_byte_q <= pend_byte_d;
      clr_pend_q  <= clr_pend_d;
      lcd_req_o   <= req_d;
      lcd_rs_o    <= rs_d;
      lcd_data_o  <= data_d;
      rx_en_o     <= init_done_d && (cnt_d != CNT_W'(FIFO_DEPTH));
      fifo_ovf_o  <= fifo_ovf_o | (rx_valid_i && full && !pop);
      busy_o      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_lcd_ctrl.sv
// Self-checking bench for uart_lcd_ctrl: auto-acking LCD driver, transfer monitor and a cursor/display reference model.
module tb_uart_lcd_ctrl;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LCD_COLS   = 16;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       rx_valid = 1'b0, rx_break = 1'b0, lcd_ack;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en, lcd_req, lcd_rs, fifo_ovf, busy;
  logic [7:0] lcd_data;

  int n_tests = 0, n_fail = 0;

  uart_lcd_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .LCD_COLS(LCD_COLS)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_break_i(rx_break), .rx_en_o(rx_en), .lcd_req_o(lcd_req), .lcd_rs_o(lcd_rs),
    .lcd_data_o(lcd_data), .lcd_ack_i(lcd_ack), .fifo_ovf_o(fifo_ovf), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // LCD driver model: acks ack_dly cycles after it sees a request
  bit ack_en = 1'b0;
  int ack_dly = 3;
  int wcnt = 0;
  initial begin
    lcd_ack = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (ack_en) begin
        if (lcd_ack) begin lcd_ack = 1'b0; wcnt = 0; end
        else if (lcd_req) begin
          if (wcnt + 1 >= ack_dly) lcd_ack = 1'b1;
          else wcnt++;
        end
      end else wcnt = 0;
    end
  end

  // Transfer monitor: logs accepted transfers, counts handshake protocol violations
  logic [8:0] xfer_q[$];
  int viol = 0;
  initial begin
    logic p_req, p_ack;
    logic [8:0] p_word;
    p_req = 1'b0; p_ack = 1'b0; p_word = '0;
    forever begin
      @(negedge clk);
      if (p_req && p_ack && lcd_req) viol++;
      if (p_req && !p_ack && lcd_req && {lcd_rs, lcd_data} != p_word) viol++;
      if (lcd_req && lcd_ack) xfer_q.push_back({lcd_rs, lcd_data});
      p_req = lcd_req; p_ack = lcd_ack; p_word = {lcd_rs, lcd_data};
    end
  end

  // Reference model of the display cursor, producing the expected transfer list
  logic [8:0] exp_q[$];
  int m_col = 0;
  bit m_line = 1'b0;
  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (m_col == LCD_COLS) begin
        m_line = !m_line; m_col = 0;
        exp_q.push_back({1'b0, (m_line ? 8'hC0 : 8'h80)});
      end
      exp_q.push_back({1'b1, b});
      m_col++;
    end else if (b == 8'h0A || b == 8'h0D) begin
      m_line = !m_line; m_col = 0;
      exp_q.push_back({1'b0, (m_line ? 8'hC0 : 8'h80)});
    end else if (b == 8'h0C) begin
      exp_q.push_back({1'b0, 8'h01});
      m_line = 1'b0; m_col = 0;
    end
  endfunction

  function automatic void model_init();
    exp_q.push_back({1'b0, 8'h38}); exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06}); exp_q.push_back({1'b0, 8'h01});
    m_col = 0; m_line = 1'b0;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!rx_en && t < 500) begin tick(); t++; end
    if (!rx_en) begin
      n_tests++; n_fail++;
      $display("FAIL send_byte_timeout rx_en=%b required 1", rx_en);
    end
    rx_valid = 1'b1; rx_data = b; tick(); rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int q = 0, t = 0;
    while (q < 3 && t < 3000) begin tick(); t++; q = busy ? 0 : q + 1; end
    if (q < 3) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle_timeout busy=%b required 0", busy);
    end
  endtask

  task automatic wait_req();
    int t = 0;
    while (!lcd_req && t < 50) begin tick(); t++; end
    if (!lcd_req) begin
      n_tests++; n_fail++;
      $display("FAIL wait_req_timeout lcd_req=%b required 1", lcd_req);
    end
  endtask

  task automatic check_xfers(input string name, input int base);
    n_tests++;
    if (xfer_q.size() - base != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count got %0d required %0d", name, xfer_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [8:0] got;
      got = (base + i < xfer_q.size()) ? xfer_q[base + i] : 9'h1FF;
      n_tests++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s[%0d] got rs=%b data=%h required rs=%b data=%h",
                 name, i, got[8], got[7:0], exp_q[i][8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic test_reset();
    int base;
    rst_n = 1'b0; ack_en = 1'b0; tick(2);
    n_tests++; if (lcd_req !== 1'b0)   begin n_fail++; $display("FAIL rst_req got %b required 0", lcd_req); end
    n_tests++; if (lcd_rs !== 1'b0)    begin n_fail++; $display("FAIL rst_rs got %b required 0", lcd_rs); end
    n_tests++; if (lcd_data !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h required 00", lcd_data); end
    n_tests++; if (rx_en !== 1'b0)     begin n_fail++; $display("FAIL rst_rx_en got %b required 0", rx_en); end
    n_tests++; if (fifo_ovf !== 1'b0)  begin n_fail++; $display("FAIL rst_ovf got %b required 0", fifo_ovf); end
    n_tests++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL rst_busy got %b required 1", busy); end
    exp_q.delete(); model_init();
    base = xfer_q.size();
    ack_dly = 3; ack_en = 1'b1; rst_n = 1'b1;
    wait_idle();
    check_xfers("init", base);
    n_tests++; if (rx_en !== 1'b1) begin n_fail++; $display("FAIL init_rx_en got %b required 1", rx_en); end
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL init_busy got %b required 0", busy); end
  endtask

  task automatic test_single_char();
    int base = xfer_q.size();
    exp_q.delete();
    rx_valid = 1'b1; rx_data = 8'h41; tick(); rx_valid = 1'b0;
    tick();
    n_tests++; if (lcd_req !== 1'b0) begin n_fail++; $display("FAIL latency_early got %b required 0", lcd_req); end
    tick();
    n_tests++; if (lcd_req !== 1'b1) begin n_fail++; $display("FAIL latency_req got %b required 1", lcd_req); end
    model_byte(8'h41);
    wait_idle();
    check_xfers("single", base);
  endtask

  task automatic test_wrap();
    int base = xfer_q.size();
    exp_q.delete();
    send_byte(8'h0C); model_byte(8'h0C);
    for (int i = 0; i < 33; i++) begin send_byte(8'h30); model_byte(8'h30); end
    wait_idle();
    check_xfers("wrap", base);
  endtask

  task automatic test_ctrl_bytes();
    int base = xfer_q.size();
    logic [7:0] seq [3];
    seq[0] = 8'h0D; seq[1] = 8'h0C; seq[2] = 8'h07;
    exp_q.delete();
    foreach (seq[i]) begin send_byte(seq[i]); model_byte(seq[i]); end
    for (int i = 0; i <= LCD_COLS; i++) begin send_byte(8'h5A); model_byte(8'h5A); end
    wait_idle();
    check_xfers("ctrl", base);
  endtask

  task automatic test_push_pop_full();
    int base = xfer_q.size();
    int t = 0;
    logic [7:0] b;
    exp_q.delete();
    ack_en = 1'b0;
    send_byte(8'h0C); model_byte(8'h0C);
    wait_req();
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      b = 8'($urandom_range(32, 126));
      rx_valid = 1'b1; rx_data = b; tick(); model_byte(b);
    end
    rx_valid = 1'b0; tick();
    n_tests++; if (rx_en !== 1'b0) begin n_fail++; $display("FAIL full_rx_en got %b required 0", rx_en); end
    ack_dly = 1; ack_en = 1'b1;
    while (!lcd_ack && t < 50) begin tick(); t++; end
    tick();
    b = 8'($urandom_range(32, 126));
    rx_valid = 1'b1; rx_data = b; tick(); rx_valid = 1'b0; model_byte(b);
    tick();
    n_tests++; if (fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf got %b required 0", fifo_ovf); end
    wait_idle();
    check_xfers("pushpop", base);
  endtask

  task automatic test_overflow();
    int base = xfer_q.size();
    logic [7:0] b;
    exp_q.delete();
    ack_en = 1'b0;
    send_byte(8'h0C); model_byte(8'h0C);
    wait_req();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      b = 8'($urandom_range(32, 126));
      rx_valid = 1'b1; rx_data = b; tick();
      if (i < FIFO_DEPTH) model_byte(b);
    end
    rx_valid = 1'b0;
    n_tests++; if (fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b required 1", fifo_ovf); end
    n_tests++; if (rx_en !== 1'b0)    begin n_fail++; $display("FAIL ovf_rx_en got %b required 0", rx_en); end
    ack_dly = 2; ack_en = 1'b1;
    wait_idle();
    check_xfers("ovf", base);
    n_tests++; if (fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b required 1", fifo_ovf); end
  endtask

  task automatic test_break();
    int base = xfer_q.size();
    logic [7:0] b;
    exp_q.delete();
    ack_en = 1'b0;
    send_byte(8'h58); model_byte(8'h58);
    wait_req();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(32, 126));
      rx_valid = 1'b1; rx_data = b; tick();
`ifndef UART_LCD_BREAK_CLEAR_EN
      model_byte(b);
`endif
    end
    rx_valid = 1'b0;
    rx_break = 1'b1; tick(); rx_break = 1'b0;
`ifdef UART_LCD_BREAK_CLEAR_EN
    exp_q.push_back({1'b0, 8'h01}); m_col = 0; m_line = 1'b0;
`endif
    tick(3);
    ack_dly = 2; ack_en = 1'b1;
    for (int i = 0; i <= LCD_COLS; i++) begin send_byte(8'h61); model_byte(8'h61); end
    wait_idle();
    check_xfers("break", base);
  endtask

  task automatic test_random();
    int base = xfer_q.size();
    logic [7:0] b;
    int r;
    exp_q.delete();
    ack_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      b = 8'($urandom_range(32, 126));
      else if (r < 86) b = (r[0]) ? 8'h0A : 8'h0D;
      else if (r < 90) b = 8'h0C;
      else             b = 8'($urandom_range(127, 255));
      ack_dly = $urandom_range(1, 4);
      send_byte(b); model_byte(b);
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 6));
    end
    wait_idle();
    check_xfers("random", base);
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL handshake_violations got %0d required 0", viol); end
  endtask

  task automatic test_reset_midtransfer();
    int base;
    ack_en = 1'b0;
    send_byte(8'h51);
    wait_req();
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (lcd_req !== 1'b0)  begin n_fail++; $display("FAIL async_req got %b required 0", lcd_req); end
    n_tests++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL async_busy got %b required 1", busy); end
    n_tests++; if (fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL async_ovf got %b required 0", fifo_ovf); end
    tick(2);
    exp_q.delete(); model_init();
    base = xfer_q.size();
    ack_dly = 2; ack_en = 1'b1; rst_n = 1'b1;
    wait_idle();
    check_xfers("reinit", base);
    n_tests++; if (rx_en !== 1'b1) begin n_fail++; $display("FAIL reinit_rx_en got %b required 1", rx_en); end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_wrap();
    test_ctrl_bytes();
    test_push_pop_full();
    test_overflow();
    test_break();
    test_random();
    test_reset_midtransfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
